// File: rtl/mito_host_sequencer_pkg.sv
// Shared types and constants for the MITO host-side sequencer.
// Mode encodings, FSM states and instruction word field positions.
package mito_pkg;

  localparam logic [1:0] MODE_CONVOL = 2'b01;
  localparam logic [1:0] MODE_FULLY  = 2'b10;
  localparam logic [1:0] MODE_POOL   = 2'b11;

  localparam int INS_MODE_LSB = 0;
  localparam int INS_START    = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    STREAM,
    WAIT
  } state_t;

endpackage

// File: rtl/mito_sync_fifo.sv
// Synchronous show-ahead FIFO: rdata_o always shows the head entry.
// Pointers carry one extra MSB so full and empty are distinguishable.
module mito_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              push_ok;
  logic              pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mito_host_sequencer.sv
// Host end of the MITO accelerator port set: buffers a payload, issues the
// instruction, streams words gap-free and queues results for the host.
module mito_host_sequencer
  import mito_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [7:0]        cmd_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  output logic [DATA_W-1:0] instruction_signal,
  output logic [DATA_W-1:0] MITO_input,
  input  logic [DATA_W-1:0] MITO_output,
  input  logic              ready_finish,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              err_len,
  output logic              err_timeout,
  output logic              err_ovf
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT) + 1;

  state_t            state_q;
  logic [1:0]        mode_q;
  logic [7:0]        len_q;
  logic [7:0]        sent_q;
  logic [TO_W-1:0]   wait_cnt_q;
  logic              captured_q;
  logic [DATA_W-1:0] ins_q;
  logic [DATA_W-1:0] min_q;
  logic [DATA_W-1:0] hold_q;
  logic              err_len_q, err_timeout_q, err_ovf_q;

  logic              pl_push, pl_pop, pl_full, pl_empty;
  logic [DATA_W-1:0] pl_head;
  logic [CNT_W-1:0]  pl_count;
  logic              res_push, res_full, res_empty;
  logic [DATA_W-1:0] res_head;
  logic [CNT_W-1:0]  res_count;
  logic [DATA_W-1:0] ins_run, ins_go;
  logic              len_legal;

  assign len_legal = (cmd_len != 8'd0) && (32'(cmd_len) <= FIFO_DEPTH);
  assign pl_ready  = (state_q == LOAD) && !pl_full && (8'(pl_count) != len_q);
  assign pl_push   = pl_valid && pl_ready;
  assign pl_pop    = ((state_q == ISSUE) || (state_q == STREAM && sent_q != len_q)) && !pl_empty;
  assign res_push  = (state_q == WAIT) && ready_finish;

  always_comb begin
    ins_run = '0;
    ins_run[INS_MODE_LSB +: 2] = mode_q;
    ins_go = ins_run;
    ins_go[INS_START] = 1'b1;
  end

  mito_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_pl_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(pl_push), .wdata_i(pl_data), .pop_i(pl_pop), .rdata_o(pl_head),
    .full_o(pl_full), .empty_o(pl_empty), .count_o(pl_count)
  );

  mito_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(res_push), .wdata_i(MITO_output), .pop_i(res_ready), .rdata_o(res_head),
    .full_o(res_full), .empty_o(res_empty), .count_o(res_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_q        <= '0;
      len_q         <= '0;
      sent_q        <= '0;
      wait_cnt_q    <= '0;
      captured_q    <= 1'b0;
      ins_q         <= '0;
      min_q         <= '0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            mode_q        <= cmd_mode;
            len_q         <= cmd_len;
            err_len_q     <= !len_legal;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            if (len_legal) state_q <= LOAD;
          end
        end
        LOAD: begin
          if (8'(pl_count) == len_q) begin
            state_q <= ISSUE;
            ins_q   <= ins_go;
          end
        end
        ISSUE: begin
          state_q <= STREAM;
          ins_q   <= ins_run;
          min_q   <= pl_head;
          sent_q  <= 8'd1;
        end
        STREAM: begin
          if (sent_q == len_q) begin
            state_q    <= WAIT;
            min_q      <= '0;
            wait_cnt_q <= '0;
            captured_q <= 1'b0;
          end else begin
            min_q  <= pl_head;
            sent_q <= sent_q + 8'd1;
          end
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + TO_W'(1);
          if (ready_finish) begin
            captured_q <= 1'b1;
            if (res_full && !res_ready) err_ovf_q <= 1'b1;
          end else if (captured_q) begin
            // First low cycle after a capture is the falling edge of ready_finish.
            state_q <= IDLE;
            ins_q   <= '0;
          end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
            ins_q         <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Keeps the last visible head so res_data does not wander once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else if (!res_empty) hold_q <= res_head;
  end

  assign cmd_ready          = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign instruction_signal = ins_q;
  assign MITO_input         = min_q;
  assign res_valid          = (res_count != '0);
  assign res_data           = res_empty ? hold_q : res_head;
  assign err_len            = err_len_q;
  assign err_timeout        = err_timeout_q;
  assign err_ovf            = err_ovf_q;

endmodule
